// File: rtl/aucohl_sdm_dac_pkg.sv
// Shared types for the first-order sigma-delta DAC controller.
// State encodings are fixed so debug taps read the same values across the codebase.
package aucohl_sdm_dac_pkg;

    typedef enum logic [1:0] {
        SDM_IDLE  = 2'd0,
        SDM_PRIME = 2'd1,
        SDM_RUN   = 2'd2
    } sdm_state_e;

endpackage

// File: rtl/aucohl_sdm1.sv
// First-order sigma-delta core: SIZE-bit accumulator whose carry-out is the registered density bit.
// clr zeroes both the accumulator and the output bit; step advances one modulator tick.
module aucohl_sdm1 #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            step,
    input  logic [SIZE-1:0] x,
    output logic            dout
);

    logic [SIZE-1:0] acc;
    logic [SIZE:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            dout <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            dout <= 1'b0;
        end else if (step) begin
            acc  <= sum[SIZE-1:0];
            dout <= sum[SIZE];
        end
    end

endmodule

// File: rtl/aucohl_sdm_dac.sv
// Sigma-delta DAC controller: buffers one sample from a valid/ready stream and
// modulates each sample for (osr+1) ticks of a (clk_div+1)-clock tick period.
module aucohl_sdm_dac
    import aucohl_sdm_dac_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [W-1:0]    clk_div,
    input  logic [W-1:0]    osr,
    input  logic [SIZE-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            dout,
    output logic            underrun,
    output logic            active
);

    sdm_state_e      state, state_nx;
    logic [SIZE-1:0] nxt, cur;
    logic            nxt_valid;
    logic [W-1:0]    tick_ctr, smp_ctr;
    logic            tick, boundary, mod_step, mod_clr;

    assign tick     = (tick_ctr == '0);
    assign boundary = tick && (smp_ctr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SDM_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = SDM_IDLE;
        end else begin
            case (state)
                SDM_IDLE:  state_nx = SDM_PRIME;
                SDM_PRIME: if (nxt_valid) state_nx = SDM_RUN;
                SDM_RUN:   state_nx = SDM_RUN;
                default:   state_nx = SDM_IDLE;
            endcase
        end
    end

    always_comb begin
        active  = (state == SDM_RUN);
        s_ready = en && (state != SDM_IDLE) && !nxt_valid;
    end

    // The accumulator only runs in RUN; every other state (and en=0) holds it at zero,
    // which gives the clean start on RUN entry.
    assign mod_step = en && (state == SDM_RUN) && tick;
    assign mod_clr  = !en || (state != SDM_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt       <= '0;
            nxt_valid <= 1'b0;
            cur       <= '0;
            tick_ctr  <= '0;
            smp_ctr   <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (!en) begin
                nxt_valid <= 1'b0;
            end else begin
                // s_ready excludes nxt_valid, so a load here never races a consume below.
                if (s_valid && s_ready) begin
                    nxt       <= s_data;
                    nxt_valid <= 1'b1;
                end
                case (state)
                    SDM_PRIME: begin
                        if (nxt_valid) begin
                            cur       <= nxt;
                            nxt_valid <= 1'b0;
                            tick_ctr  <= '0;
                            smp_ctr   <= osr;
                        end
                    end
                    SDM_RUN: begin
                        if (tick) begin
                            tick_ctr <= clk_div;
                            if (boundary) begin
                                smp_ctr <= osr;
                                if (nxt_valid) begin
                                    cur       <= nxt;
                                    nxt_valid <= 1'b0;
                                end else begin
                                    underrun <= 1'b1;
                                end
                            end else begin
                                smp_ctr <= smp_ctr - W'(1);
                            end
                        end else begin
                            tick_ctr <= tick_ctr - W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    aucohl_sdm1 #(.SIZE(SIZE)) u_sdm1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mod_clr),
        .step  (mod_step),
        .x     (cur),
        .dout  (dout)
    );

endmodule

// File: tb/tb_aucohl_sdm_dac.sv
// Directed bench for aucohl_sdm_dac: a per-tick accumulator model fills expected-bit and
// expected-underrun queues that are popped on each modulator tick and compared against the DUT.
module tb_aucohl_sdm_dac;

    logic       clk = 1'b0;
    logic       rst_n, en, s_valid;
    logic [7:0] clk_div, osr, s_data;
    logic       s_ready, dout, underrun, active;

    int         checks = 0;
    int         errors = 0;
    int         ones_lo, ones_hi;
    logic [7:0] smp[$];

    always #5 clk = ~clk;

    aucohl_sdm_dac #(.SIZE(8), .W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clk_div  (clk_div),
        .osr      (osr),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .dout     (dout),
        .underrun (underrun),
        .active   (active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Streams smp[] from IDLE and checks dout/underrun/active every cycle and the handshake spacing.
    task automatic run(input int cd, input int os, input int n_ticks);
        logic [7:0] acc;
        logic [8:0] sum;
        bit         eb[$];
        bit         eu[$];
        int         ci, nsamp, idx, cyc, e, tk, last_x, nx, guard, budget, gap;
        bit         xfer, tick_prev;
        logic       exp_d, exp_u;
        nsamp = smp.size();
        acc = 8'h00;
        ci = 0;
        for (int j = 0; j < n_ticks; j++) begin
            sum = {1'b0, acc} + {1'b0, smp[ci]};
            eb.push_back(sum[8]);
            acc = sum[7:0];
            if (j % (os + 1) == os) begin
                if (ci + 1 < nsamp) begin
                    ci++;
                    eu.push_back(1'b0);
                end else begin
                    eu.push_back(1'b1);
                end
            end else begin
                eu.push_back(1'b0);
            end
        end
        clk_div = 8'(cd);
        osr = 8'(os);
        en = 1'b1;
        idx = 0;
        s_data = smp[0];
        s_valid = 1'b1;
        cyc = 0; e = -1; tk = 0; last_x = 0; nx = 0; guard = 0;
        budget = n_ticks * (cd + 1) + 20;
        exp_d = 1'b0; exp_u = 1'b0; tick_prev = 1'b0;
        ones_lo = 0; ones_hi = 0;
        forever begin
            @(negedge clk);
            chk("dout", dout, exp_d);
            chk("underrun", underrun, exp_u);
            chk("active", active, (e >= 0 && cyc >= e + 1));
            if (tick_prev) begin
                if (tk <= 256) ones_lo += int'(dout);
                else           ones_hi += int'(dout);
            end
            if (tk >= n_ticks || guard > budget) break;
            xfer = s_valid && s_ready;
            @(posedge clk);
            cyc++;
            guard++;
            if (xfer) begin
                if (e < 0) begin
                    e = cyc;
                end else begin
                    if (nx == 1)      gap = 2;
                    else if (nx == 2) gap = 1 + os * (cd + 1);
                    else              gap = (os + 1) * (cd + 1);
                    chk("xfer_gap", cyc - last_x, gap);
                end
                last_x = cyc;
                nx++;
                idx++;
            end
            tick_prev = (e >= 0 && cyc >= e + 2 && ((cyc - e - 2) % (cd + 1)) == 0);
            if (tick_prev) begin
                exp_d = eb.pop_front();
                exp_u = eu.pop_front();
                tk++;
            end else begin
                exp_u = 1'b0;
            end
            #1;
            if (idx < nsamp) s_data = smp[idx];
            else             s_valid = 1'b0;
        end
        if (tk < n_ticks) chk("tick_timeout", tk, n_ticks);
    endtask

    task automatic abort_run();
        en = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        clk_div = 8'h00; osr = 8'h00;
        #12;
        chk("rst_dout", dout, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Half scale, tick every clock: alternating dout, one transfer per 4 clocks.
        smp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run(0, 3, 16);
        abort_run();

        // Full-range endpoints over 256-tick samples.
        smp = '{8'h00, 8'hFF};
        run(0, 255, 512);
        chk("density_00", ones_lo, 0);
        chk("density_FF", ones_hi, 255);
        abort_run();

        // Slow tick: dout may only move on tick edges, one transfer per 16 clocks.
        smp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run(3, 3, 12);
        abort_run();

        // Single sample then starvation: underrun each period, density held at 1/4.
        smp = '{8'h40};
        run(0, 3, 16);
        abort_run();

        // Mixed data with a divided tick.
        smp = '{8'h33, 8'hC5, 8'h01, 8'hFE, 8'h7F};
        run(1, 2, 15);
        abort_run();

        // Abort mid-RUN with a buffered sample.
        smp = '{8'h80, 8'h80, 8'h80, 8'h80};
        run(0, 7, 4);
        en = 1'b0;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_active", active, 1'b0);
        chk("abort_dout", dout, 1'b0);
        chk("abort_s_ready", s_ready, 1'b0);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reprime_s_ready", s_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("prime_underrun", underrun, 1'b0);
            chk("prime_active", active, 1'b0);
            chk("prime_dout", dout, 1'b0);
        end
        abort_run();

        // Asynchronous reset between edges while dout is high.
        smp = '{8'h80, 8'h80, 8'h80, 8'h80};
        run(0, 3, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, 1'b0);
        chk("arst_underrun", underrun, 1'b0);
        chk("arst_active", active, 1'b0);
        chk("arst_s_ready", s_ready, 1'b0);
        en = 1'b0;
        s_valid = 1'b0;
        #5;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_active", active, 1'b0);
            chk("post_rst_s_ready", s_ready, 1'b0);
        end
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_prime", s_ready, 1'b1);
        abort_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
